// File: rtl/pulse_width_meter.sv
// Measures every qualified high pulse on a and queues width records
// in a show-ahead FIFO drained over a valid/ready port.
module pulse_width_meter #(
  parameter int W_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_WIDTH-1:0] out_width,
  output logic               out_sat,
  output logic               out_single,
  output logic [7:0]         drop_cnt,
  output logic               busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = DEPTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIGH
  } state_e;

  typedef struct packed {
    logic [W_WIDTH-1:0] w;
    logic               sat;
    logic               single;
  } rec_t;

  state_e             state_q;
  logic [W_WIDTH-1:0] cnt_q;
  logic               sat_q;
  logic               busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!a) state_q <= ARMED;
        end
        ARMED: begin
          if (a) begin
            state_q <= HIGH;
            cnt_q   <= W_WIDTH'(1);
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (a) begin
            if (&cnt_q) sat_q <= 1'b1;
            else        cnt_q <= cnt_q + W_WIDTH'(1);
          end else begin
            state_q <= ARMED;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic          push, pop, full, empty, wr_en;
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d, fill;
  logic [7:0]    drop_q, drop_d;
  rec_t          rec_d, head;
  rec_t          mem [DEPTH];

  assign push  = (state_q == HIGH) && !a;
  assign rec_d = '{w: cnt_q, sat: sat_q,
                   single: (cnt_q == W_WIDTH'(1)) && !sat_q};

  // Pointers carry extra bits so fill is a plain difference
  assign fill  = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (fill == PW'(DEPTH));
  assign pop   = !empty && out_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    drop_d = drop_q;
    if (wr_en) wr_d = wr_q + PW'(1);
    if (pop)   rd_d = rd_q + PW'(1);
    if (push && full && !pop && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= rec_d;
  end

  assign head       = mem[rd_q[AW-1:0]];
  assign out_valid  = !empty;
  assign out_width  = out_valid ? head.w : '0;
  assign out_sat    = out_valid && head.sat;
  assign out_single = out_valid && head.single;
  assign drop_cnt   = drop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: run-length reference model
// feeds an expected-record queue popped by a handshake monitor.
module tb_pulse_width_meter;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int WMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         a = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_width;
  logic         out_sat;
  logic         out_single;
  logic [7:0]   drop_cnt;
  logic         busy;

  pulse_width_meter #(.W_WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_width  (out_width),
    .out_sat    (out_sat),
    .out_single (out_single),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    bit sat;
    bit single;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference: a pulse is a run of highs that began after some low
  bit seen_low;
  int run_len;
  int mcount;
  int mdrop;

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, exp, $time);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_low <= 1'b0;
      run_len  <= 0;
      mcount   <= 0;
      mdrop    <= 0;
      sb.delete();
    end else begin
      automatic bit pop = (mcount > 0) && out_ready;
      automatic int cnt = mcount;
      automatic int drp = mdrop;
      if (a) begin
        if (seen_low) run_len <= run_len + 1;
      end else begin
        if (run_len > 0) begin
          automatic rec_t r;
          r.w      = (run_len > WMAX) ? WMAX : run_len;
          r.sat    = run_len > WMAX;
          r.single = run_len == 1;
          if (cnt < D || pop) begin
            sb.push_back(r);
            cnt++;
          end else if (drp < 255) begin
            drp++;
          end
        end
        run_len  <= 0;
        seen_low <= 1'b1;
      end
      if (pop) cnt--;
      mcount <= cnt;
      mdrop  <= drp;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", int'(out_valid), int'(mcount > 0));
      chk("busy", int'(busy), int'(run_len > 0));
      chk("drop_cnt", int'(drop_cnt), mdrop);
      if (!out_valid) begin
        chk("idle_width", int'(out_width), 0);
        chk("idle_flags", int'({out_sat, out_single}), 0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          automatic rec_t e = sb.pop_front();
          chk("width", int'(out_width), e.w);
          chk("sat", int'(out_sat), int'(e.sat));
          chk("single", int'(out_single), int'(e.single));
        end
      end
    end
  end

  task automatic drive(input bit av, input bit rv);
    a         = av;
    out_ready = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int w, input bit rv);
    for (int i = 0; i < w; i++) drive(1'b1, rv);
    drive(1'b0, rv);
  endtask

  task automatic zero_outputs(input string n);
    chk({n, "_valid"}, int'(out_valid), 0);
    chk({n, "_width"}, int'(out_width), 0);
    chk({n, "_sat"}, int'(out_sat), 0);
    chk({n, "_single"}, int'(out_single), 0);
    chk({n, "_drop"}, int'(drop_cnt), 0);
    chk({n, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset(input bit av);
    #2;
    rst = 1'b1;
    a   = av;
    #1;
    zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    a = 1'b0;
    while (out_valid && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", int'(out_valid), 0);
  endtask

  initial begin
    do_reset(1'b0);

    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("single_latency", int'(out_valid), 1);
    drain();

    do_reset(1'b1);
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    pulse(2, 1'b0);
    chk("w2_width", int'(out_width), 2);
    drain();

    drive(1'b0, 1'b1);
    pulse(300, 1'b1);
    chk("sat_width", int'(out_width), WMAX);
    chk("sat_flag", int'(out_sat), 1);
    drain();

    for (int w = 1; w <= 6; w++) pulse(w, 1'b0);
    chk("drop_two", int'(drop_cnt), 2);
    drain();

    for (int w = 1; w <= 4; w++) pulse(w, 1'b0);
    repeat (7) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    chk("full_pop_drop", int'(drop_cnt), 2);
    drive(1'b0, 1'b0);
    drain();

    pulse(3, 1'b0);
    pulse(1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    zero_outputs("async_rst");
    @(posedge clk);
    #1;
    a   = 1'b0;
    rst = 1'b0;
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("post_rst_width", int'(out_width), 1);
    drain();

    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
    drain();

    for (int i = 0; i < 280; i++) pulse(1, 1'b0);
    chk("drop_sat", int'(drop_cnt), 255);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
